// File: rtl/pixel_pkg.sv
// Shared screen geometry, colours, FIFO entry layout and state encoding
// for the pixel plot buffer.
package pixel_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] YELLOW = 3'b110;

    // A null entry still carries a frame marker but must never be plotted.
    typedef struct packed {
        logic       last;
        logic       is_null;
        logic [2:0] color;
        logic [6:0] y;
        logic [7:0] x;
    } pixel_entry_t;

    localparam int ENTRY_W = $bits(pixel_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    function automatic logic in_screen(input logic [7:0] x, input logic [6:0] y,
                                       input int w, input int h);
        return (int'(x) < w) && (int'(y) < h);
    endfunction

endpackage

// File: rtl/pixel_plot_buffer_if.sv
// Pixel stream from a screen drawer into the plot buffer.
interface pixel_plot_buffer_if;

    logic       in_valid;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_color;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid, in_x, in_y, in_color, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color, in_last,
        output in_ready
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel entries; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  pixel_entry_t wdata,
    input  logic         pop,
    output pixel_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_entry_t   mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_plot_buffer.sv
// Buffers drawer pixels, drops repeats and off-screen pixels, and drives the
// VGA adapter plot port; can also sweep the whole screen with one colour.
module pixel_plot_buffer #(
    parameter int         DEPTH       = 16,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] CLEAR_COLOR = 3'b000,
    parameter bit         DEDUP       = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear_req,
    pixel_plot_buffer_if.slave px,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_color,
    output logic               plot,
    output logic               frame_done,
    output logic               clear_done,
    output logic               busy,
    output logic [7:0]         drop_count
);

    import pixel_pkg::*;

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_t       state;
    pixel_entry_t wr_entry;
    pixel_entry_t rd_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         accept;
    logic         in_range;
    logic         is_dup;
    logic         push;
    logic         pop;
    logic [17:0]  last_pix;
    logic         last_valid;
    logic [7:0]   cx;
    logic [6:0]   cy;
    logic         sweep_end;

    assign px.in_ready = (state == ST_IDLE) && !fifo_full && !clear_req;
    assign accept      = px.in_valid && px.in_ready;
    assign in_range    = in_screen(px.in_x, px.in_y, SCREEN_W, SCREEN_H);
    assign is_dup      = DEDUP && last_valid &&
                         ({px.in_color, px.in_y, px.in_x} == last_pix);

    // Frame markers always survive so the consumer sees every frame end.
    assign push      = accept && (px.in_last || (in_range && !is_dup));
    assign pop       = !fifo_empty && (state != ST_CLEAR);
    assign sweep_end = (state == ST_CLEAR) && (cx == X_LAST) && (cy == Y_LAST);
    assign busy      = !((state == ST_IDLE) && fifo_empty);

    assign wr_entry = '{last:    px.in_last,
                        is_null: !in_range,
                        color:   px.in_color,
                        y:       px.in_y,
                        x:       px.in_x};

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (wr_entry),
        .pop    (pop),
        .rdata  (rd_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count <= '0;
            last_pix   <= '0;
            last_valid <= 1'b0;
        end else begin
            if (accept && !px.in_last && !in_range && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (push && px.in_last) begin
                last_valid <= 1'b0;
            end else if (push) begin
                last_pix   <= {px.in_color, px.in_y, px.in_x};
                last_valid <= 1'b1;
            end else if (sweep_end) begin
                last_valid <= 1'b0;
            end
        end
    end

    // Pop and sweep never overlap, so the plot registers have one owner per cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_color  <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            plot       <= 1'b0;
            frame_done <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_CLEAR;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                ST_CLEAR: begin
                    plot      <= 1'b1;
                    vga_x     <= cx;
                    vga_y     <= cy;
                    vga_color <= CLEAR_COLOR;
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) begin
                            clear_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (pop) begin
                vga_x      <= rd_entry.x;
                vga_y      <= rd_entry.y;
                vga_color  <= rd_entry.color;
                plot       <= !rd_entry.is_null;
                frame_done <= rd_entry.last;
            end
        end
    end

endmodule

// File: doc/pixel_plot_buffer.md
Name: pixel_plot_buffer

Overview:
- Downstream stage for the screen drawers (start-screen letter drawer, game field, end screen). It consumes their x/y/colour pixel stream and drives the VGA adapter's plot interface.
- It buffers pixels in a small FIFO and drops consecutive duplicate pixels; the drawers clamp their offsets and repeat the same pixel for many cycles.
- It clips pixels that fall outside the 160x120 screen.
- It can paint the whole frame a single colour before the next screen is drawn.

Parameters:
- DEPTH, 16: FIFO entries (power of 2, minimum 4).
- SCREEN_W, 160: visible columns; x >= SCREEN_W is out of range.
- SCREEN_H, 120: visible rows; y >= SCREEN_H is out of range.
- CLEAR_COLOR, 3'b000: colour used by the clear sweep.
- DEDUP, 1: 1 enables duplicate suppression; 0 disables it.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- clear_req  in  1  level; request a full-screen clear.
- in_valid  in  1  input pixel valid.
- in_x  in  8  pixel column.
- in_y  in  7  pixel row.
- in_color  in  3  pixel colour.
- in_last  in  1  marks the final pixel of a drawer's frame (the drawer's done signal).
- in_ready  out  1  buffer accepts a beat this cycle.
- vga_x  out  8  plot column, registered.
- vga_y  out  7  plot row, registered.
- vga_color  out  3  plot colour, registered.
- plot  out  1  write-enable to the VGA adapter, registered.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is popped.
- clear_done  out  1  one-cycle pulse at the end of a clear sweep.
- busy  out  1  high unless state is IDLE and the FIFO is empty.
- drop_count  out  8  saturating count of beats dropped as out-of-range.

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset:
  - FIFO empty; state IDLE.
  - All outputs 0: plot, frame_done, clear_done, vga_x/y/color, drop_count.
  - Last-pixel register invalid.
- States: IDLE, DRAIN, CLEAR.
- in_ready = (state == IDLE) && !fifo_full && !clear_req.
- A beat is accepted when in_valid && in_ready.
- Write rules for an accepted beat:
  - in_last = 1: always written; stored null if out of range.
  - Out of range (x >= SCREEN_W or y >= SCREEN_H) with in_last = 0: dropped; drop_count += 1, saturating at 255.
  - DEDUP = 1, last-pixel register valid, and {x,y,color} equal to it: dropped; not counted.
  - Otherwise: written; the last-pixel register loads {x,y,color} and becomes valid.
- Last-pixel register is invalidated after a written in_last beat and at the end of CLEAR.
- Read side:
  - If the FIFO is non-empty and state != CLEAR, pop one entry per cycle.
  - On the following edge, vga_* take the entry's values; plot = !null; frame_done = entry's last flag.
  - Otherwise plot = 0 and frame_done = 0.
- Latency: a beat accepted at edge k into an empty FIFO has plot high in the cycle after edge k+1. Throughput is 1 pixel/cycle.
- Simultaneous push and pop with the FIFO full is not possible, since in_ready is low when full. Push and pop in the same cycle on a non-empty FIFO leaves the occupancy unchanged.
- Clear sequence:
  - IDLE with clear_req = 1: go to DRAIN; in_ready is already low.
  - DRAIN with FIFO empty: go to CLEAR and zero the counters cx, cy.
  - CLEAR: each cycle drive plot = 1, vga_x = cx, vga_y = cy, vga_color = CLEAR_COLOR.
  - cx counts 0..SCREEN_W-1; when cx wraps, cy += 1.
  - After (SCREEN_W-1, SCREEN_H-1): pulse clear_done, go to IDLE. The sweep is exactly SCREEN_W*SCREEN_H plot cycles (19200 with defaults).
- clear_req is re-sampled only in IDLE. Holding it high causes back-to-back clears.
- Reset mid-operation, including mid-sweep: immediate return to reset state. No partial-frame pulses are produced.
- Width rules: cx is 8-bit and cy is 7-bit; comparisons are unsigned.

Decomposition:
- Package pixel_pkg:
  - SCREEN_W, SCREEN_H.
  - Colour constants BLACK = 3'b000, YELLOW = 3'b110.
  - Pixel-entry packing {last, null, color, y, x} = 20 bits.
  - State encodings.
- Sub-module pixel_fifo: synchronous FIFO, DEPTH x 20 bits, with full/empty/push/pop.

Test Plan:
- Single beat: (61,27,3'b110) accepted at edge 0 -> plot = 1 with vga = 61/27/110 in the cycle after edge 1; plot = 0 afterwards.
- Duplicate suppression: same beat held valid for 50 cycles -> exactly 1 plot; drop_count stays 0. Same test with DEDUP = 0 -> 50 plots.
- Clipping: x = 200, then y = 125, then (10,10) -> 1 plot at (10,10); drop_count = 2.
- Out-of-range last beat: x = 170 with in_last = 1 -> no plot; frame_done pulses once; the next identical in-range pixel is plotted because the last-pixel register was invalidated.
- Clear: clear_req with 3 beats queued -> 3 plots, then 19200 plots of colour 000. First plot is (0,0), last is (159,119). clear_done pulses once; in_ready is low throughout.
- Reset at sweep pixel 5000 -> all outputs 0 on the next cycle; no clear_done; the next clear restarts at (0,0).
